// File: rtl/sbqm_pkg.sv
// Shared types and constants for the SBqM queue event generator.
// The pulse FSM states and the occupancy width live here so every block agrees on them.
package sbqm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    GAP  = 2'd2
  } pulseState_t;

  localparam int SBQM_MAX_COUNT = 7;
  localparam int SBQM_CNT_W     = 3;

  // Smallest counter width that can hold the value n.
  function automatic int widthFor(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One photocell channel: 2-flop synchronizer, debounce filter, and a strobe on each
// accepted 1->0 transition of the filtered level (beam newly broken).
module sensor_debounce
  import sbqm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic fallEvent
);

  localparam int CW = widthFor(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(DEBOUNCE_CYCLES - 1);

  logic          syncA;
  logic          syncB;
  logic          level;
  logic [CW-1:0] stableCnt;
  logic          accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncA <= 1'b1;
      syncB <= 1'b1;
    end else begin
      syncA <= raw;
      syncB <= syncA;
    end
  end

  // The strobe is combinational so the pulse FSM can react on the very edge the level flips.
  assign accept    = (syncB != level) && (stableCnt == LAST_SAMPLE);
  assign fallEvent = accept && !syncB;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level     <= 1'b1;
      stableCnt <= '0;
    end else if (syncB == level) begin
      stableCnt <= '0;
    end else if (accept) begin
      level     <= syncB;
      stableCnt <= '0;
    end else begin
      stableCnt <= stableCnt + CW'(1);
    end
  end

endmodule

// File: rtl/queue_event_gen.sv
// Turns debounced entry/exit photocell events into clean active-low up/down pulses for
// the queue counter, serializing simultaneous events and mirroring the issued count.
module queue_event_gen
  import sbqm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LOW       = 2,
  parameter int PULSE_GAP       = 2,
  parameter int MAX_COUNT       = SBQM_MAX_COUNT,
  parameter int PEND_MAX        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  entrySensor,
  input  logic                  exitSensor,
  output logic                  upSignal,
  output logic                  downSignal,
  output logic [SBQM_CNT_W-1:0] occupancy,
  output logic                  full,
  output logic                  empty,
  output logic                  dropEvent
);

  localparam int PW   = widthFor(PEND_MAX);
  localparam int TMAX = (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
  localparam int TW   = widthFor(TMAX);

  localparam logic [PW-1:0]         PEND_TOP = PW'(PEND_MAX);
  localparam logic [TW-1:0]         LOW_LAST = TW'(PULSE_LOW - 1);
  localparam logic [TW-1:0]         GAP_LAST = TW'(PULSE_GAP - 1);
  localparam logic [SBQM_CNT_W-1:0] OCC_TOP  = SBQM_CNT_W'(MAX_COUNT);

  pulseState_t           state, nextState;
  logic [TW-1:0]         timer, nextTimer;
  logic [PW-1:0]         pendUp, pendDown, nextPendUp, nextPendDown;
  logic [SBQM_CNT_W-1:0] nextOcc;
  logic                  nextUpSignal, nextDownSignal;
  logic                  lastUp, nextLastUp;
  logic                  pickUp;
  logic                  consumeUp, consumeDown;
  logic                  fsmDrop, satDropUp, satDropDown;
  logic                  evtUp, evtDown;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) entryFilter (
    .clk       (clk),
    .reset     (reset),
    .raw       (entrySensor),
    .fallEvent (evtUp)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) exitFilter (
    .clk       (clk),
    .reset     (reset),
    .raw       (exitSensor),
    .fallEvent (evtDown)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      upSignal   <= 1'b1;
      downSignal <= 1'b1;
      occupancy  <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      dropEvent  <= 1'b0;
      pendUp     <= '0;
      pendDown   <= '0;
      lastUp     <= 1'b0;
    end else begin
      state      <= nextState;
      timer      <= nextTimer;
      upSignal   <= nextUpSignal;
      downSignal <= nextDownSignal;
      occupancy  <= nextOcc;
      full       <= (nextOcc == OCC_TOP);
      empty      <= (nextOcc == '0);
      dropEvent  <= fsmDrop | satDropUp | satDropDown;
      pendUp     <= nextPendUp;
      pendDown   <= nextPendDown;
      lastUp     <= nextLastUp;
    end
  end

  // Round robin starts with lastUp=0 so the first contested pick goes to up; a pick
  // that gets discarded at a bound still counts as served for fairness.
  always_comb begin
    nextState      = state;
    nextTimer      = timer;
    nextUpSignal   = upSignal;
    nextDownSignal = downSignal;
    nextOcc        = occupancy;
    nextLastUp     = lastUp;
    pickUp         = 1'b0;
    consumeUp      = 1'b0;
    consumeDown    = 1'b0;
    fsmDrop        = 1'b0;
    case (state)
      IDLE: begin
        if ((pendUp != '0) || (pendDown != '0)) begin
          pickUp     = (pendUp != '0) && ((pendDown == '0) || !lastUp);
          nextLastUp = pickUp;
          if (pickUp) begin
            consumeUp = 1'b1;
            if (full) begin
              fsmDrop = 1'b1;
            end else begin
              nextUpSignal = 1'b0;
              nextTimer    = '0;
              nextState    = LOW;
            end
          end else begin
            consumeDown = 1'b1;
            if (empty) begin
              fsmDrop = 1'b1;
            end else begin
              nextDownSignal = 1'b0;
              nextTimer      = '0;
              nextState      = LOW;
            end
          end
        end
      end
      LOW: begin
        if (timer == LOW_LAST) begin
          nextUpSignal   = 1'b1;
          nextDownSignal = 1'b1;
          nextOcc        = !upSignal ? occupancy + SBQM_CNT_W'(1)
                                     : occupancy - SBQM_CNT_W'(1);
          nextTimer      = '0;
          nextState      = GAP;
        end else begin
          nextTimer = timer + TW'(1);
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          nextTimer = '0;
          nextState = IDLE;
        end else begin
          nextTimer = timer + TW'(1);
        end
      end
      default: begin
        nextState = IDLE;
        nextTimer = '0;
      end
    endcase
  end

  // A new event and a consumption in the same cycle cancel, so saturation only drops
  // an event when the counter really has no room left.
  always_comb begin
    nextPendUp   = pendUp;
    nextPendDown = pendDown;
    satDropUp    = 1'b0;
    satDropDown  = 1'b0;
    if (evtUp && !consumeUp) begin
      if (pendUp == PEND_TOP) satDropUp = 1'b1;
      else                    nextPendUp = pendUp + PW'(1);
    end else if (!evtUp && consumeUp) begin
      nextPendUp = pendUp - PW'(1);
    end
    if (evtDown && !consumeDown) begin
      if (pendDown == PEND_TOP) satDropDown = 1'b1;
      else                      nextPendDown = pendDown + PW'(1);
    end else if (!evtDown && consumeDown) begin
      nextPendDown = pendDown - PW'(1);
    end
  end

endmodule
